hs_bus_arbiter: RTL and testbench

//  Shares one handshake interconnect port between the instruction fetch and data access requesters.

---
 rtl/hs_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_hs_bus_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_bus_arbiter.sv
// Shares one handshake interconnect port between instruction fetch and data access (data has priority).
// Latency: a new request reaches the bus 1 cycle after it is raised; each grant is followed by 1 quiet cycle.
// Backpressure: requests are held until x_ready_o; bus_ready_i stalls the granted port (zero-wait allowed).
//
// Ports:
//   clk_i, rst_i                  clock (rising edge), synchronous active-high reset
//   instr_rd_i/addr_i             instruction read request and address
//   instr_data_o/ready_o          instruction read data, idle/completion
//   data_rd_i/wr_i/addr_i/wdata_i data read/write request, address, write data
//   data_rdata_o/ready_o          data read data, idle/completion
//   bus_rd_o/wr_o/addr_o/data_o   interconnect request side
//   bus_data_i/ready_i            interconnect read data and completion
//   grant_o                       {data,instr} current grant, one-hot or zero
module hs_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_CONSEC = 4     // 1..15, fits the 4-bit starvation counter
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instr_rd_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic [DATA_W-1:0] instr_data_o,
    output logic              instr_ready_o,
    input  logic              data_rd_i,
    input  logic              data_wr_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_ready_o,
    output logic              bus_rd_o,
    output logic              bus_wr_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    input  logic [DATA_W-1:0] bus_data_i,
    input  logic              bus_ready_i,
    output logic [1:0]        grant_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_CONSEC);

    state_t            state;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] instr_rdata_reg;
    logic [DATA_W-1:0] data_rdata_reg;
    logic              data_req;
    logic              instr_done;
    logic              data_done;
    logic              data_win;

    assign data_req   = data_rd_i | data_wr_i;
    // A completion needs the granted requester still asserting, so a
    // dropped request can never be completed by a late bus_ready_i.
    assign instr_done = (state == GRANT_I) && instr_rd_i && bus_ready_i;
    assign data_done  = (state == GRANT_D) && data_req && bus_ready_i;
    // Data wins arbitration unless instr has already waited out MAX_CONSEC data grants.
    assign data_win   = data_req && (!instr_rd_i || (cnt < MAX_CNT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            instr_rdata_reg <= '0;
            data_rdata_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_win) begin
                        state <= GRANT_D;
                    end else if (instr_rd_i) begin
                        state <= GRANT_I;
                    end
                end
                GRANT_I: begin
                    if (!instr_rd_i) begin
                        state <= IDLE;
                    end else if (bus_ready_i) begin
                        state <= RELEASE;
                    end
                end
                GRANT_D: begin
                    if (!data_req) begin
                        state <= IDLE;
                    end else if (bus_ready_i) begin
                        state <= RELEASE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (instr_done) begin
                cnt             <= 4'd0;
                instr_rdata_reg <= bus_data_i;
            end
            if (data_done) begin
                if (data_rd_i) begin
                    data_rdata_reg <= bus_data_i;
                end
                if (!instr_rd_i) begin
                    cnt <= 4'd0;
                end else if (cnt != MAX_CNT) begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

    // Bus request mirrors the granted port; everything is forced to zero otherwise.
    always_comb begin
        bus_rd_o   = 1'b0;
        bus_wr_o   = 1'b0;
        bus_addr_o = '0;
        bus_data_o = '0;
        case (state)
            GRANT_I: begin
                bus_rd_o   = instr_rd_i;
                bus_addr_o = instr_addr_i;
            end
            GRANT_D: begin
                bus_rd_o   = data_rd_i;
                bus_wr_o   = data_wr_i;
                bus_addr_o = data_addr_i;
                bus_data_o = data_wdata_i;
            end
            default: ;
        endcase
    end

    assign grant_o       = {state == GRANT_D, state == GRANT_I};
    assign instr_ready_o = !instr_rd_i || instr_done;
    assign data_ready_o  = !data_req || data_done;
    // Read data bypasses the holding register in the completion cycle.
    assign instr_data_o  = instr_done ? bus_data_i : instr_rdata_reg;
    assign data_rdata_o  = (data_done && data_rd_i) ? bus_data_i : data_rdata_reg;

endmodule

// File: tb/tb_hs_bus_arbiter.sv
// Self-checking bench for hs_bus_arbiter: directed vector table, multi-cycle corner sequences,
// then randomized requesters checked against a rule-level reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_hs_bus_arbiter;

    localparam int MAXC = 4;

    logic        clk;
    logic        rst;
    logic        instr_rd;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        instr_ready;
    logic        data_rd;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [31:0] bus_data_out;
    logic [31:0] bus_data_in;
    logic        bus_ready;
    logic [1:0]  grant;

    hs_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_CONSEC(MAXC)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_rd_i    (instr_rd),
        .instr_addr_i  (instr_addr),
        .instr_data_o  (instr_data),
        .instr_ready_o (instr_ready),
        .data_rd_i     (data_rd),
        .data_wr_i     (data_wr),
        .data_addr_i   (data_addr),
        .data_wdata_i  (data_wdata),
        .data_rdata_o  (data_rdata),
        .data_ready_o  (data_ready),
        .bus_rd_o      (bus_rd),
        .bus_wr_o      (bus_wr),
        .bus_addr_o    (bus_addr),
        .bus_data_o    (bus_data_out),
        .bus_data_i    (bus_data_in),
        .bus_ready_i   (bus_ready),
        .grant_o       (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        i_rd;
        logic [31:0] i_addr;
        logic        d_rd;
        logic        d_wr;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] b_rdata;
        logic        b_rdy;
        logic        e_brd;
        logic        e_bwr;
        logic [31:0] e_baddr;
        logic [31:0] e_bdata;
        logic [1:0]  e_grant;
        logic        e_irdy;
        logic        e_drdy;
        logic [31:0] e_idata;
        logic [31:0] e_ddata;
    } vec_t;

    localparam logic [31:0] VA = 32'h1111_1111;
    localparam logic [31:0] VB = 32'h4444_4444;
    localparam logic [31:0] VC = 32'h5555_5555;
    localparam logic [31:0] VD = 32'hCAFE_0001;
    localparam logic [31:0] WD = 32'hDEAD_BEEF;

    vec_t     vecs[$];
    logic [1:0] kinds[16];
    logic     rdy_level;

    // Hold current requests, feed fresh read data, and record the grant of each completion.
    task automatic collect(input int n, output int got);
        got = 0;
        for (int c = 0; c < 300 && got < n; c++) begin
            @(negedge clk);
            bus_data_in = $urandom | 32'h1;
            bus_ready   = rdy_level;
            #1;
            if ((bus_rd || bus_wr) && bus_ready && grant != 2'b00) begin
                kinds[got] = grant;
                got++;
            end
        end
        if (got < n) chk("collect_timeout", got, n);
    endtask

    // Reference model state for the random phase
    int         m_cnt;
    logic [31:0] m_ireg, m_dreg;
    logic [1:0] prev_grant;
    logic       prev_comp, prev_quiet, prev_ireq, prev_dreq;
    logic       i_act, d_act, d_is_wr, i_done, d_done;

    initial begin
        int          got;
        logic [1:0]  exp_g;
        logic        quiet, e_ci, e_cd, dreq, e_brd, e_bwr;
        logic [31:0] e_baddr, e_bdata;
        logic [1:0]  exp_t4[10];
        logic [1:0]  exp_t5[5];

        rst = 1'b1; instr_rd = 0; instr_addr = 0; data_rd = 0; data_wr = 0;
        data_addr = 0; data_wdata = 0; bus_data_in = 0; bus_ready = 0; rdy_level = 1'b1;

        //                i_rd i_addr      d_rd d_wr d_addr      d_wdata  b_rdata        rdy | brd bwr baddr       bdata  grant  irdy drdy idata ddata
        // T1: instr read, zero-wait
        vecs.push_back(vec_t'{1, 32'h100, 0, 0, 32'h0, 32'h0, VA, 1,  0, 0, 32'h0, 32'h0, 2'b00, 0, 1, 32'h0, 32'h0});
        vecs.push_back(vec_t'{1, 32'h100, 0, 0, 32'h0, 32'h0, VA, 1,  1, 0, 32'h100, 32'h0, 2'b01, 1, 1, VA, 32'h0});
        vecs.push_back(vec_t'{0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h22222222, 1,  0, 0, 32'h0, 32'h0, 2'b00, 1, 1, VA, 32'h0});
        vecs.push_back(vec_t'{0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h22222222, 1,  0, 0, 32'h0, 32'h0, 2'b00, 1, 1, VA, 32'h0});
        // T2: data write, 3 wait cycles
        vecs.push_back(vec_t'{0, 32'h0, 0, 1, 32'h2000, WD, 32'h0, 0,  0, 0, 32'h0, 32'h0, 2'b00, 1, 0, VA, 32'h0});
        vecs.push_back(vec_t'{0, 32'h0, 0, 1, 32'h2000, WD, 32'h0, 0,  0, 1, 32'h2000, WD, 2'b10, 1, 0, VA, 32'h0});
        vecs.push_back(vec_t'{0, 32'h0, 0, 1, 32'h2000, WD, 32'h0, 0,  0, 1, 32'h2000, WD, 2'b10, 1, 0, VA, 32'h0});
        vecs.push_back(vec_t'{0, 32'h0, 0, 1, 32'h2000, WD, 32'h0, 0,  0, 1, 32'h2000, WD, 2'b10, 1, 0, VA, 32'h0});
        vecs.push_back(vec_t'{0, 32'h0, 0, 1, 32'h2000, WD, 32'h33333333, 1,  0, 1, 32'h2000, WD, 2'b10, 1, 1, VA, 32'h0});
        vecs.push_back(vec_t'{0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h33333333, 1,  0, 0, 32'h0, 32'h0, 2'b00, 1, 1, VA, 32'h0});
        vecs.push_back(vec_t'{0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h33333333, 1,  0, 0, 32'h0, 32'h0, 2'b00, 1, 1, VA, 32'h0});
        // T3: simultaneous requests, data first
        vecs.push_back(vec_t'{1, 32'h300, 1, 0, 32'h4000, 32'h0, VB, 1,  0, 0, 32'h0, 32'h0, 2'b00, 0, 0, VA, 32'h0});
        vecs.push_back(vec_t'{1, 32'h300, 1, 0, 32'h4000, 32'h0, VB, 1,  1, 0, 32'h4000, 32'h0, 2'b10, 0, 1, VA, VB});
        vecs.push_back(vec_t'{1, 32'h300, 0, 0, 32'h0, 32'h0, VC, 1,  0, 0, 32'h0, 32'h0, 2'b00, 0, 1, VA, VB});
        vecs.push_back(vec_t'{1, 32'h300, 0, 0, 32'h0, 32'h0, VC, 1,  0, 0, 32'h0, 32'h0, 2'b00, 0, 1, VA, VB});
        vecs.push_back(vec_t'{1, 32'h300, 0, 0, 32'h0, 32'h0, VC, 1,  1, 0, 32'h300, 32'h0, 2'b01, 1, 1, VC, VB});
        vecs.push_back(vec_t'{0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h66666666, 1,  0, 0, 32'h0, 32'h0, 2'b00, 1, 1, VC, VB});
        vecs.push_back(vec_t'{0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h66666666, 1,  0, 0, 32'h0, 32'h0, 2'b00, 1, 1, VC, VB});
        // T6: instr read data held afterwards while bus data moves
        vecs.push_back(vec_t'{1, 32'h500, 0, 0, 32'h0, 32'h0, VD, 1,  0, 0, 32'h0, 32'h0, 2'b00, 0, 1, VC, VB});
        vecs.push_back(vec_t'{1, 32'h500, 0, 0, 32'h0, 32'h0, VD, 1,  1, 0, 32'h500, 32'h0, 2'b01, 1, 1, VD, VB});
        vecs.push_back(vec_t'{0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h12345678, 1,  0, 0, 32'h0, 32'h0, 2'b00, 1, 1, VD, VB});
        vecs.push_back(vec_t'{0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h9ABCDEF0, 0,  0, 0, 32'h0, 32'h0, 2'b00, 1, 1, VD, VB});

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_bus_rd", 32'(bus_rd), 32'h0);
        chk("rst_idata", instr_data, 32'h0);
        chk("rst_ddata", data_rdata, 32'h0);
        chk("rst_irdy", 32'(instr_ready), 32'h1);
        chk("rst_drdy", 32'(data_ready), 32'h1);
        rst = 1'b0;

        foreach (vecs[k]) begin
            @(negedge clk);
            instr_rd = vecs[k].i_rd;   instr_addr = vecs[k].i_addr;
            data_rd = vecs[k].d_rd;    data_wr = vecs[k].d_wr;
            data_addr = vecs[k].d_addr; data_wdata = vecs[k].d_wdata;
            bus_data_in = vecs[k].b_rdata; bus_ready = vecs[k].b_rdy;
            #1;
            chk($sformatf("row%0d bus_rd", k), 32'(bus_rd), 32'(vecs[k].e_brd));
            chk($sformatf("row%0d bus_wr", k), 32'(bus_wr), 32'(vecs[k].e_bwr));
            chk($sformatf("row%0d bus_addr", k), bus_addr, vecs[k].e_baddr);
            chk($sformatf("row%0d bus_data", k), bus_data_out, vecs[k].e_bdata);
            chk($sformatf("row%0d grant", k), 32'(grant), 32'(vecs[k].e_grant));
            chk($sformatf("row%0d instr_ready", k), 32'(instr_ready), 32'(vecs[k].e_irdy));
            chk($sformatf("row%0d data_ready", k), 32'(data_ready), 32'(vecs[k].e_drdy));
            chk($sformatf("row%0d instr_data", k), instr_data, vecs[k].e_idata);
            chk($sformatf("row%0d data_rdata", k), data_rdata, vecs[k].e_ddata);
        end

        // T4: both held continuously, data back-to-back: 4 data, then instr, repeated
        exp_t4 = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        @(negedge clk);
        instr_rd = 1; instr_addr = 32'h600; data_rd = 1; data_addr = 32'h7000; bus_ready = 1;
        rdy_level = 1'b1;
        collect(10, got);
        for (int k = 0; k < 10; k++)
            if (k < got) chk($sformatf("t4_seq%0d", k), 32'(kinds[k]), 32'(exp_t4[k]));

        // T5: build cnt to 2, then reset during a data-write wait
        @(negedge clk);
        data_rd = 0; data_wr = 1; data_wdata = 32'hA5A5_5A5A;
        collect(2, got);
        for (int k = 0; k < 2; k++)
            if (k < got) chk($sformatf("t5_pre%0d", k), 32'(kinds[k]), 32'h2);
        rdy_level = 1'b0;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk);
            bus_ready = 0;
            #1;
            if (grant == 2'b10) got = 1;
        end
        if (got == 0) chk("t5_wait_grant_timeout", 32'(grant), 32'h2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_no_ready_in_rst", 32'(data_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_bus_wr", 32'(bus_wr), 32'h0);
        chk("t5_grant", 32'(grant), 32'h0);
        chk("t5_drdy", 32'(data_ready), 32'h0);
        chk("t5_irdy", 32'(instr_ready), 32'h0);
        chk("t5_idata", instr_data, 32'h0);
        chk("t5_ddata", data_rdata, 32'h0);
        // A cleared counter lets data take the full 4 grants before instr
        exp_t5 = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        rdy_level = 1'b1;
        collect(5, got);
        for (int k = 0; k < 5; k++)
            if (k < got) chk($sformatf("t5_post%0d", k), 32'(kinds[k]), 32'(exp_t5[k]));

        // Random phase
        @(negedge clk);
        rst = 1'b1; instr_rd = 0; data_rd = 0; data_wr = 0; bus_ready = 0;
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0; m_ireg = 0; m_dreg = 0;
        prev_grant = 2'b00; prev_comp = 0; prev_quiet = 0; prev_ireq = 0; prev_dreq = 0;
        i_act = 0; d_act = 0; d_is_wr = 0; i_done = 0; d_done = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (i_done) i_act = 0;
            if (d_done) d_act = 0;
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1; instr_addr = $urandom;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1; d_is_wr = 1'($urandom_range(0, 1));
                data_addr = $urandom; data_wdata = $urandom;
            end
            instr_rd = i_act;
            data_rd = d_act && !d_is_wr;
            data_wr = d_act && d_is_wr;
            bus_ready = ($urandom_range(0, 2) != 0);
            bus_data_in = $urandom;
            #1;
            dreq = data_rd | data_wr;
            // Grant expected from the previous cycle's observable history
            quiet = 0;
            if (prev_comp) begin
                exp_g = 2'b00; quiet = 1;
            end else if (prev_grant != 2'b00) begin
                exp_g = ((prev_grant == 2'b01) ? prev_ireq : prev_dreq) ? prev_grant : 2'b00;
            end else if (prev_quiet) begin
                exp_g = 2'b00;
            end else if (prev_dreq && (!prev_ireq || m_cnt < MAXC)) begin
                exp_g = 2'b10;
            end else if (prev_ireq) begin
                exp_g = 2'b01;
            end else begin
                exp_g = 2'b00;
            end
            e_brd = 0; e_bwr = 0; e_baddr = 0; e_bdata = 0;
            if (exp_g == 2'b01) begin
                e_brd = instr_rd; e_baddr = instr_addr;
            end else if (exp_g == 2'b10) begin
                e_brd = data_rd; e_bwr = data_wr; e_baddr = data_addr; e_bdata = data_wdata;
            end
            e_ci = (exp_g == 2'b01) && instr_rd && bus_ready;
            e_cd = (exp_g == 2'b10) && dreq && bus_ready;
            chk($sformatf("rnd%0d grant", cyc), 32'(grant), 32'(exp_g));
            chk($sformatf("rnd%0d bus_rd", cyc), 32'(bus_rd), 32'(e_brd));
            chk($sformatf("rnd%0d bus_wr", cyc), 32'(bus_wr), 32'(e_bwr));
            chk($sformatf("rnd%0d bus_addr", cyc), bus_addr, e_baddr);
            chk($sformatf("rnd%0d bus_data", cyc), bus_data_out, e_bdata);
            chk($sformatf("rnd%0d instr_ready", cyc), 32'(instr_ready), 32'(!instr_rd || e_ci));
            chk($sformatf("rnd%0d data_ready", cyc), 32'(data_ready), 32'(!dreq || e_cd));
            chk($sformatf("rnd%0d instr_data", cyc), instr_data, e_ci ? bus_data_in : m_ireg);
            chk($sformatf("rnd%0d data_rdata", cyc), data_rdata, (e_cd && data_rd) ? bus_data_in : m_dreg);
            if (e_ci) begin
                m_ireg = bus_data_in;
                m_cnt = 0;
            end
            if (e_cd) begin
                if (data_rd) m_dreg = bus_data_in;
                m_cnt = instr_rd ? ((m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1) : 0;
            end
            prev_quiet = quiet;
            prev_comp = e_ci | e_cd;
            prev_grant = exp_g;
            prev_ireq = instr_rd;
            prev_dreq = dreq;
            i_done = e_ci;
            d_done = e_cd;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
